// File: rtl/posit_mul_sched.sv
// Round-robin scheduler sharing one pipelined posit multiplier among NREQ requesters,
// with a credit-protected result FIFO. Optional counters enabled by MSCHED_STATS_EN.
module posit_mul_sched #(
    parameter int WIDTH      = 8,
    parameter int NREQ       = 4,
    parameter int MUL_LAT    = 1,
    parameter int RES_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_vld,
    output logic [NREQ-1:0]          req_rdy,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    output logic                     mul_vld_o,
    output logic [WIDTH-1:0]         mul_a_o,
    output logic [WIDTH-1:0]         mul_b_o,
    input  logic [RES_W-1:0]         mul_res_i,
    input  logic                     flush_i,
    output logic                     flush_done,
    output logic                     res_vld,
    input  logic                     res_rdy,
    output logic [RES_W-1:0]         res_data,
    output logic [$clog2(NREQ)-1:0]  res_id
`ifdef MSCHED_STATS_EN
    ,
    output logic [31:0]              stat_issue,
    output logic [31:0]              stat_stall
`endif
);
    localparam int ID_W  = $clog2(NREQ);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                          state_q, state_d;
    logic [ID_W-1:0]                 rr_q, rr_d;
    logic                            flush_prev_q, flush_prev_d;
    logic                            mul_vld_q, mul_vld_d;
    logic [WIDTH-1:0]                mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [ID_W-1:0]                 iss_id_q, iss_id_d;
    logic [MUL_LAT-1:0]              tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0]    tag_id_q, tag_id_d;
    logic [FIFO_DEPTH-1:0][RES_W-1:0] mem_data_q, mem_data_d;
    logic [FIFO_DEPTH-1:0][ID_W-1:0] mem_id_q, mem_id_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d, infl_q, infl_d;
    logic                            flush_done_q, flush_done_d;

    logic            flush_rise, grant_en, found, grant, push, pop;
    logic [ID_W-1:0] gnt_id;
    int              idx;

    // Credits are taken from registered state only: a pop frees its slot one cycle later.
    always_comb begin
        flush_rise = flush_i && !flush_prev_q;
        grant_en   = !rst && (state_q == S_RUN) && !flush_rise &&
                     (int'(cnt_q) + int'(infl_q) < FIFO_DEPTH);
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req_vld[idx]) begin
                found  = 1'b1;
                gnt_id = ID_W'(idx);
            end
        end
        grant   = grant_en && found;
        req_rdy = '0;
        if (grant) req_rdy[gnt_id] = 1'b1;
    end

    always_comb begin
        push         = tag_vld_q[MUL_LAT-1];
        pop          = (cnt_q != '0) && res_rdy;
        flush_prev_d = flush_i;

        rr_d      = rr_q;
        mul_vld_d = grant;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        iss_id_d  = iss_id_q;
        if (grant) begin
            rr_d     = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            mul_a_d  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
            mul_b_d  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
            iss_id_d = gnt_id;
        end

        // Tag pipe mirrors the multiplier latency; its tail marks a valid mul_res_i.
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = mul_vld_q;
        tag_id_d[0]  = iss_id_q;
        for (int i = 1; i < MUL_LAT; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        infl_d = infl_q + CNT_W'(grant) - CNT_W'(push);
        cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);

        mem_data_d = mem_data_q;
        mem_id_d   = mem_id_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = mul_res_i;
            mem_id_d[wr_ptr_q]   = tag_id_q[MUL_LAT-1];
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

        // DRAIN looks at next-cycle occupancy so flush_done follows the last pop directly.
        state_d      = state_q;
        flush_done_d = 1'b0;
        case (state_q)
            S_RUN:   if (flush_rise) state_d = S_DRAIN;
            S_DRAIN: if (cnt_d == '0 && infl_d == '0) begin
                         state_d      = S_DONE;
                         flush_done_d = 1'b1;
                     end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q      <= S_RUN;
            rr_q         <= '0;
            flush_prev_q <= 1'b0;
            mul_vld_q    <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            iss_id_q     <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            mem_data_q   <= '0;
            mem_id_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            infl_q       <= '0;
            flush_done_q <= 1'b0;
        end else begin
            assert (!(push && !pop && cnt_q == CNT_W'(FIFO_DEPTH)))
                else $error("result FIFO overflow");
            state_q      <= state_d;
            rr_q         <= rr_d;
            flush_prev_q <= flush_prev_d;
            mul_vld_q    <= mul_vld_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            iss_id_q     <= iss_id_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            mem_data_q   <= mem_data_d;
            mem_id_q     <= mem_id_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            infl_q       <= infl_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign mul_vld_o  = mul_vld_q;
    assign mul_a_o    = mul_a_q;
    assign mul_b_o    = mul_b_q;
    assign flush_done = flush_done_q;
    assign res_vld    = (cnt_q != '0);
    assign res_data   = mem_data_q[rd_ptr_q];
    assign res_id     = mem_id_q[rd_ptr_q];

`ifdef MSCHED_STATS_EN
    logic [31:0] stat_issue_q, stat_issue_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issue_d = stat_issue_q;
        stat_stall_d = stat_stall_q;
        if (mul_vld_q && stat_issue_q != '1) stat_issue_d = stat_issue_q + 1'b1;
        if (|req_vld && !grant && stat_stall_q != '1) stat_stall_d = stat_stall_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            stat_issue_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_issue_q <= stat_issue_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_issue = stat_issue_q;
    assign stat_stall = stat_stall_q;
`endif
endmodule
